// File: rtl/rc5_enc_16bit.sv
// One-round RC5 encryption (w=8, 16-bit block) with a start/done handshake.
// Optional macro RC5_BUSY_EN adds a registered busy output high in RND_A/RND_B.
module rc5_enc_16bit #(
    parameter logic [7:0] S0 = 8'h20,
    parameter logic [7:0] S1 = 8'h10,
    parameter logic [7:0] S2 = 8'hFF,
    parameter logic [7:0] S3 = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enc_start,
    input  logic [15:0] p,
    output logic [15:0] c,
    output logic        enc_done
`ifdef RC5_BUSY_EN
    ,
    output logic        busy
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RND_A = 2'd1,
        RND_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] a_rnd;
    logic [7:0] b_rnd;

    // Only the low 3 bits of the rotate amount matter for an 8-bit word.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // In RND_B, a already holds the value written during RND_A.
    assign a_rnd = rotl8(a ^ b, b[2:0]) + S2;
    assign b_rnd = rotl8(b ^ a, a[2:0]) + S3;

`ifdef RC5_BUSY_EN
    logic busy_r;
    assign busy = busy_r;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            a        <= 8'h00;
            b        <= 8'h00;
            c        <= 16'h0000;
            enc_done <= 1'b0;
`ifdef RC5_BUSY_EN
            busy_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    enc_done <= 1'b0;
                    if (enc_start) begin
                        a     <= p[15:8] + S0;
                        b     <= p[7:0] + S1;
                        state <= RND_A;
`ifdef RC5_BUSY_EN
                        busy_r <= 1'b1;
`endif
                    end
                end
                RND_A: begin
                    a     <= a_rnd;
                    state <= RND_B;
                end
                RND_B: begin
                    b        <= b_rnd;
                    c        <= {a, b_rnd};
                    enc_done <= 1'b1;
                    state    <= DONE;
`ifdef RC5_BUSY_EN
                    busy_r   <= 1'b0;
`endif
                end
                DONE: begin
                    // Result stays presented until the controller drops its request.
                    if (!enc_start) begin
                        enc_done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    enc_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_enc_16bit.sv
// Self-checking bench for rc5_enc_16bit: directed vectors plus random plaintexts
// compared against a plain-arithmetic RC5 reference.
module tb_rc5_enc_16bit;

    logic        clock;
    logic        reset;
    logic        enc_start;
    logic [15:0] p;
    logic [15:0] c;
    logic        enc_done;
`ifdef RC5_BUSY_EN
    logic        busy;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rc5_enc_16bit dut (
        .clock    (clock),
        .reset    (reset),
        .enc_start(enc_start),
        .p        (p),
        .c        (c),
        .enc_done (enc_done)
`ifdef RC5_BUSY_EN
        ,
        .busy     (busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int rot(input int x, input int n);
        int k;
        k = n % 8;
        return ((x << k) | (x >> (8 - k))) % 256;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] pt);
        int av, bv;
        av = (int'(pt[15:8]) + 32'h20) % 256;
        bv = (int'(pt[7:0]) + 32'h10) % 256;
        av = (rot(av ^ bv, bv) + 255) % 256;
        bv = (rot(bv ^ av, av) + 255) % 256;
        return 16'((av << 8) | bv);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        enc_start = 1'b0;
        #1;
        chk("rst_c", 32'(c), 32'h0);
        chk("rst_done", 32'(enc_done), 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Runs one encryption, scrambles p after it is sampled, holds start for
    // 'hold' cycles past done, then releases the handshake.
    task automatic run_enc(input string tag, input logic [15:0] pt, input logic [15:0] exp,
                           input int hold);
        int lat;
        int bcnt;
        logic [15:0] got;
        @(negedge clock);
        p = pt;
        enc_start = 1'b1;
        lat = 0;
        bcnt = 0;
        while (lat < 8) begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) p = 16'($urandom);
`ifdef RC5_BUSY_EN
            if (busy) bcnt++;
`endif
            if (enc_done) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_c"}, 32'(c), 32'(exp));
`ifdef RC5_BUSY_EN
        chk({tag, "_busy_cnt"}, 32'(bcnt), 32'd2);
`endif
        got = c;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk({tag, "_hold_done"}, 32'(enc_done), 32'h1);
            chk({tag, "_hold_c"}, 32'(c), 32'(got));
`ifdef RC5_BUSY_EN
            chk({tag, "_hold_busy"}, 32'(busy), 32'h0);
`endif
        end
        @(negedge clock);
        enc_start = 1'b0;
        @(posedge clock);
        #1;
        chk({tag, "_drop_done"}, 32'(enc_done), 32'h0);
        chk({tag, "_keep_c"}, 32'(c), 32'(got));
    endtask

    logic [15:0] vec_p [8] = '{16'hFFFF, 16'hAAAA, 16'h5555, 16'h00FF,
                               16'hFF00, 16'h1234, 16'h4321, 16'h567A};
    logic [15:0] vec_c [8] = '{16'h0703, 16'hC079, 16'h01C7, 16'h9665,
                               16'h0E86, 16'h6687, 16'hA393, 16'hF2E0};

    initial begin
        reset = 1'b1;
        enc_start = 1'b0;
        p = 16'h0000;
        #2;
        do_reset();

        run_enc("zero", 16'h0000, 16'h2F9E, 0);
        chk("model_zero", 32'(model(16'h0000)), 32'h2F9E);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_enc("vec", vec_p[i], vec_c[i], 0);
            chk("model_vec", 32'(model(vec_p[i])), 32'(vec_c[i]));
        end

        // Plaintext changed two cycles after start must not affect the result.
        @(negedge clock);
        p = 16'hFFFF;
        enc_start = 1'b1;
        repeat (2) @(negedge clock);
        p = 16'h0000;
        @(posedge clock);
        #1;
        chk("stable_done", 32'(enc_done), 32'h1);
        chk("stable_c", 32'(c), 32'h0703);
        @(negedge clock);
        enc_start = 1'b0;
        @(posedge clock);
        #1;
        chk("stable_drop", 32'(enc_done), 32'h0);

        // Reset while in RND_A discards the operation immediately.
        @(negedge clock);
        p = 16'h4321;
        enc_start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        enc_start = 1'b0;
        #1;
        chk("midrst_c", 32'(c), 32'h0);
        chk("midrst_done", 32'(enc_done), 32'h0);
`ifdef RC5_BUSY_EN
        chk("midrst_busy", 32'(busy), 32'h0);
`endif
        @(negedge clock);
        reset = 1'b1;
        run_enc("after_rst", 16'h0000, 16'h2F9E, 0);

        // Handshake: long hold, release, then restart.
        run_enc("hold", 16'hAAAA, 16'hC079, 5);
        run_enc("restart", 16'h1234, 16'h6687, 0);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] rp;
            rp = 16'($urandom);
            run_enc("rand", rp, model(rp), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc5_enc_16bit.md
Name: rc5_enc_16bit

Overview:
- 16-bit-block RC5 encryption engine: word size w=8, one round, fixed 4-entry expanded-key table.
- Accepts a plaintext on a start request and produces the ciphertext via a small multi-cycle FSM.
- Raises a done flag when the ciphertext is valid.
- Sits as a leaf crypto datapath under a controller that drives `enc_start` and samples `c` on `enc_done`.

Parameters:
- S0, 8'h20, expanded key word 0, added to A at pre-whitening
- S1, 8'h10, expanded key word 1, added to B at pre-whitening
- S2, 8'hFF, expanded key word 2, added in the A half-round
- S3, 8'hFF, expanded key word 3, added in the B half-round

Ports:
- clock  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low reset; 0 = reset, 1 = run
- enc_start  input  1  level request to encrypt `p`
- p  input  16  plaintext; `p[15:8]` = A word, `p[7:0]` = B word
- c  output  16  ciphertext {A,B}
- enc_done  output  1  ciphertext valid

Behaviour:
- Registers:
  - A, B: 8-bit working words.
  - FSM states: IDLE, RND_A, RND_B, DONE.
  - `c` and `enc_done` are registered.
- Reset (`reset`=0, asynchronous):
  - state=IDLE, A=B=0, `c`=16'h0000, `enc_done`=0.
  - Applies at any time, including mid-encryption; the in-flight operation is discarded.
- Arithmetic:
  - All additions are mod 2^8.
  - `rotl(x,n)` = 8-bit left rotate by `n[2:0]`, using only the 3 LSBs of the rotate amount.
- IDLE:
  - On a rising edge with `enc_start`=1: A <= `p[15:8]`+S0, B <= `p[7:0]`+S1, go to RND_A.
  - `p` is sampled only at this edge; later changes to `p` have no effect on the result.
  - Otherwise stay in IDLE.
- RND_A: A <= rotl(A^B, B)+S2; go to RND_B.
- RND_B:
  - B <= rotl(B^A_new, A_new)+S3, where A_new is the value written in RND_A.
  - `c` <= {A, B_new}, `enc_done` <= 1, go to DONE.
- DONE:
  - While `enc_start`=1: hold; `c` and `enc_done` stable.
  - When `enc_start`=0: go to IDLE and clear `enc_done`; `c` keeps its last value.
- Latency: `enc_done` goes high on the 3rd rising edge counting the edge that samples `enc_start` in IDLE.
- `enc_start` is ignored in RND_A and RND_B. A start held high does not retrigger until the FSM has passed through IDLE.
- `enc_done` is low in every state except DONE.

Optional Feature:
- Macro: RC5_BUSY_EN.
- Defined:
  - Adds output port `busy` (1 bit).
  - `busy`=1 in RND_A and RND_B, 0 otherwise; 0 during reset.
- Undefined: no `busy` port; all other behaviour identical.

Test Plan:
- Apply reset=0, then reset=1 with `enc_start`=1 and `p`=16'h0000 -> `enc_done`=1 after 3 edges with `c`=16'h2F9E.
- Single-pattern encryptions with `enc_start`=1, one per reset cycle:

  | `p` | expected `c` |
  |---|---|
  | 16'hFFFF | 16'h0703 |
  | 16'hAAAA | 16'hC079 |
  | 16'h5555 | 16'h01C7 |
  | 16'h00FF | 16'h9665 |
  | 16'hFF00 | 16'h0E86 |
  | 16'h1234 | 16'h6687 |
  | 16'h4321 | 16'hA393 |
  | 16'h567A | 16'hF2E0 |

- Plaintext stability: start with `p`=16'hFFFF, change `p` to 16'h0000 two cycles later -> `c`=16'h0703; result unaffected by the change.
- Reset mid-operation: assert reset=0 while in RND_A -> `c`=0, `enc_done`=0 immediately. A new start with `p`=16'h0000 -> `c`=16'h2F9E.
- Handshake:
  - Hold `enc_start`=1 after done -> `enc_done` stays 1 with no re-encryption.
  - Drop `enc_start` -> `enc_done`=0 next edge.
  - Re-assert `enc_start` with `p`=16'h1234 -> `c`=16'h6687.
- With RC5_BUSY_EN defined -> `busy` high for exactly 2 cycles per encryption, low in IDLE and DONE.
